// File: rtl/dmem_responder_if.sv
// Bus bundle between the memory stage, the data-memory responder and the
// byte consumer on the TX side.
//
// Handshakes: the request side (addr/wdata/wmask/ren) has no backpressure
// and is taken on every rising edge; the TX byte stream follows strict
// valid/ready: tx_data is meaningful only while tx_valid is high, a byte
// transfers on an edge where tx_valid and tx_ready are both high, and
// tx_valid/tx_data never depend combinationally on tx_ready.
interface dmem_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ren;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Requester/consumer side
    modport master (
        output addr, wdata, wmask, ren, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    // Responder side
    modport slave (
        input  addr, wdata, wmask, ren, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane writes and registered
// reads, plus a small MMIO block (STATUS, TXDATA byte FIFO, CYCLE counter).
// Region is chosen by addr[31:28]: 0x0 RAM, 0x8 MMIO, anything else reads 0.
module dmem_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PW    = $clog2(FIFO_DEPTH);
    // Count must hold 0..FIFO_DEPTH so full and empty are distinct values.
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'h8;

    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_TXDATA = 8'h04;
    localparam logic [7:0] OFS_CYCLE  = 8'h08;
    localparam logic [7:0] OFS_CYCCLR = 8'h0C;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   ram_mem [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [31:0]   rdata_q,      rdata_d;
    logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic          ovf_q,        ovf_d;
    logic [31:0]   cycle_q,      cycle_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0]       region;
    logic             ram_sel;
    logic             mmio_sel;
    logic [IDX_W-1:0] ram_idx;
    logic [7:0]       mmio_ofs;
    logic             wr_any;

    assign region   = bus.addr[31:28];
    assign ram_sel  = (region == REGION_RAM);
    assign mmio_sel = (region == REGION_MMIO);
    // Bits above the index inside the RAM region alias onto the same words.
    assign ram_idx  = bus.addr[IDX_W+1:2];
    assign mmio_ofs = bus.addr[7:0];
    assign wr_any   = |bus.wmask;

    // Address bits that no decoder looks at (aliased RAM bits, MMIO upper
    // offset bits); folded here so they are visibly intentional.
    logic unused_addr;
    assign unused_addr = ^bus.addr[27:IDX_W+2];

    // ------------------------------------------------------------------
    // FIFO status and handshake qualifiers
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic ovf_clr;
    logic cyc_clr;

    assign fifo_full  = (fifo_count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count_q == '0);

    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_data  = fifo_mem[rd_ptr_q];

    assign pop      = ~fifo_empty & bus.tx_ready;
    assign push_req = mmio_sel & (mmio_ofs == OFS_TXDATA) & bus.wmask[0];
    // A pop on the same edge frees the slot the push needs, even when full.
    assign push     = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;
    assign ovf_clr  = mmio_sel & (mmio_ofs == OFS_STATUS) & bus.wmask[0] & bus.wdata[2];
    assign cyc_clr  = mmio_sel & (mmio_ofs == OFS_CYCCLR) & wr_any;

    // ------------------------------------------------------------------
    // Read data selection
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] mmio_rdata;

    // STATUS reflects pre-edge FIFO/overflow state, before this edge's push/pop.
    assign status_word = {29'd0, ovf_q, fifo_empty, ~fifo_full};

    // MMIO read mux; CYCLE returns the count including the current edge, so
    // the first edge after reset (or after a clear) reads 1.
    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_ofs)
            OFS_STATUS: mmio_rdata = status_word;
            OFS_CYCLE:  mmio_rdata = cycle_q + 32'd1;
            default:    mmio_rdata = 32'd0;
        endcase
    end

    // Next-state logic for read data, FIFO pointers/count, overflow and cycle counter.
    always_comb begin
        rdata_d      = rdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        ovf_d        = ovf_q;
        cycle_d      = cycle_q + 32'd1;

        if (bus.ren) begin
            if (ram_sel) begin
                // Pre-write contents: the RAM update lands at the same edge.
                rdata_d = ram_mem[ram_idx];
            end else if (mmio_sel) begin
                rdata_d = mmio_rdata;
            end else begin
                rdata_d = 32'd0;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        if (cyc_clr) begin
            cycle_d = 32'd0;
        end
    end

    // Control registers: cleared asynchronously, which also discards any
    // pending read result and all queued TX bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q      <= 32'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            ovf_q        <= 1'b0;
            cycle_q      <= 32'd0;
        end else begin
            rdata_q      <= rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            ovf_q        <= ovf_d;
            cycle_q      <= cycle_d;
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_sel) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (bus.wmask[lane]) begin
                    ram_mem[ram_idx][8*lane +: 8] <= bus.wdata[8*lane +: 8];
                end
            end
        end
    end

    // FIFO entry storage; validity is tracked by the count, not the entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, read-before-write, TX FIFO
// overflow and push/pop-while-full, cycle counter clear/wrap, async reset.
module tb_dmem_responder;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
  localparam logic [31:0] A_CYCCLR = 32'h8000_000C;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  dmem_responder_if bus ();

  dmem_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic set_bus(input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input logic r);
    bus.addr  = a;
    bus.wdata = wd;
    bus.wmask = m;
    bus.ren   = r;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    set_bus(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    set_bus(A_TXDATA, {24'h0, b}, 4'b0001, 1'b0);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.tx_ready = 1'b0;
    #12;
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL reset_rdata got %h expected %h", bus.rdata, 32'h0);
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_tx_valid got %b expected 0", bus.tx_valid);
    end
    step(); step();
    reset = 1'b0;
    set_bus(A_CYCLE, 32'h0, 4'h0, 1'b1);
    step();
    n_checks++;
    if (bus.rdata !== 32'd1) begin
      n_errors++; $display("FAIL cycle_first_edge got %h expected %h", bus.rdata, 32'd1);
    end
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1);
    step();
    n_checks++;
    if (bus.rdata !== 32'h3) begin
      n_errors++; $display("FAIL status_after_reset got %h expected %h", bus.rdata, 32'h3);
    end
  endtask

  task automatic test_ram_lanes();
    set_bus(32'h0000_0010, 32'hAABB_CCDD, 4'b1111, 1'b0); step();
    set_bus(32'h0000_0010, 32'h1122_3344, 4'b0101, 1'b0); step();
    set_bus(32'h0000_0010, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'hAA22_CC44) begin
      n_errors++; $display("FAIL ram_lanes got %h expected %h", bus.rdata, 32'hAA22_CC44);
    end
    set_bus(32'h0000_0014, 32'h0, 4'h0, 1'b0); step();
    n_checks++;
    if (bus.rdata !== 32'hAA22_CC44) begin
      n_errors++; $display("FAIL rdata_hold got %h expected %h", bus.rdata, 32'hAA22_CC44);
    end
    set_bus(32'h0000_1010, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'hAA22_CC44) begin
      n_errors++; $display("FAIL ram_alias got %h expected %h", bus.rdata, 32'hAA22_CC44);
    end
    set_bus(32'h4000_0010, 32'hFFFF_FFFF, 4'b1111, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL unmapped_read got %h expected %h", bus.rdata, 32'h0);
    end
    set_bus(32'h0000_0010, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'hAA22_CC44) begin
      n_errors++; $display("FAIL unmapped_write_ignored got %h expected %h", bus.rdata, 32'hAA22_CC44);
    end
    idle();
  endtask

  task automatic test_read_before_write();
    set_bus(32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 1'b0); step();
    set_bus(32'h0000_0020, 32'h1234_5678, 4'b1111, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL rbw_old got %h expected %h", bus.rdata, 32'hDEAD_BEEF);
    end
    set_bus(32'h0000_0020, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h1234_5678) begin
      n_errors++; $display("FAIL rbw_new got %h expected %h", bus.rdata, 32'h1234_5678);
    end
    idle();
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_q[$];
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      if (i <= 4) exp_q.push_back(8'(i));
    end
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h4) begin
      n_errors++; $display("FAIL status_full_ovf got %h expected %h", bus.rdata, 32'h4);
    end
    idle();
    bus.tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.tx_valid, bus.tx_data} !== {1'b1, e}) begin
        n_errors++; $display("FAIL drain_ovf got v=%b d=%h expected v=1 d=%h", bus.tx_valid, bus.tx_data, e);
      end
      step();
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL drained_valid got %b expected 0", bus.tx_valid);
    end
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h7) begin
      n_errors++; $display("FAIL status_empty_ovf got %h expected %h", bus.rdata, 32'h7);
    end
    set_bus(A_STATUS, 32'h4, 4'b0001, 1'b0); step();
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h3) begin
      n_errors++; $display("FAIL status_ovf_clear got %h expected %h", bus.rdata, 32'h3);
    end
    idle();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q[$];
    bus.tx_ready = 1'b0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h99};
    bus.tx_ready = 1'b1;
    push_byte(8'h99);
    bus.tx_ready = 1'b0;
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL status_full_no_ovf got %h expected %h", bus.rdata, 32'h0);
    end
    idle();
    bus.tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.tx_valid, bus.tx_data} !== {1'b1, e}) begin
        n_errors++; $display("FAIL drain_pushpop got v=%b d=%h expected v=1 d=%h", bus.tx_valid, bus.tx_data, e);
      end
      step();
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL pushpop_empty got %b expected 0", bus.tx_valid);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_cycle();
    set_bus(A_CYCCLR, 32'h0, 4'b1111, 1'b0); step();
    idle(); step();
    set_bus(A_CYCLE, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'd2) begin
      n_errors++; $display("FAIL cycle_after_clear got %h expected %h", bus.rdata, 32'd2);
    end
    set_bus(A_CYCCLR, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL cycclr_read got %h expected %h", bus.rdata, 32'h0);
    end
    set_bus(A_CYCLE, 32'h0, 4'h0, 1'b1); step();
    set_bus(A_TXDATA, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL txdata_read got %h expected %h", bus.rdata, 32'h0);
    end
    set_bus(32'h8000_0010, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL mmio_other_read got %h expected %h", bus.rdata, 32'h0);
    end
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    set_bus(A_CYCLE, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL cycle_wrap got %h expected %h", bus.rdata, 32'h0);
    end
    step();
    n_checks++;
    if (bus.rdata !== 32'd1) begin
      n_errors++; $display("FAIL cycle_after_wrap got %h expected %h", bus.rdata, 32'd1);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    set_bus(32'h0000_0030, 32'hCAFE_F00D, 4'b1111, 1'b0); step();
    bus.tx_ready = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    set_bus(32'h0000_0030, 32'h0, 4'h0, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.tx_valid, bus.rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_errors++; $display("FAIL pre_reset got v=%b r=%h expected v=1 r=%h", bus.tx_valid, bus.rdata, 32'hCAFE_F00D);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_errors++; $display("FAIL async_reset_rdata got %h expected %h", bus.rdata, 32'h0);
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL async_reset_tx_valid got %b expected 0", bus.tx_valid);
    end
    idle();
    step();
    reset = 1'b0;
    set_bus(32'h0000_0030, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'hCAFE_F00D) begin
      n_errors++; $display("FAIL ram_kept_over_reset got %h expected %h", bus.rdata, 32'hCAFE_F00D);
    end
    set_bus(A_STATUS, 32'h0, 4'h0, 1'b1); step();
    n_checks++;
    if (bus.rdata !== 32'h3) begin
      n_errors++; $display("FAIL status_after_mid_reset got %h expected %h", bus.rdata, 32'h3);
    end
    idle();
  endtask

  // Sequencer and final report
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_ram_lanes();
    test_read_before_write();
    test_fifo_overflow();
    test_push_pop_full();
    test_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, giving the number of 32-bit RAM words (a power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of TX byte FIFO entries (a power of two).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  byte address from the memory stage; addr[1:0] ignored.
REQ-006 wdata  input  32  store data, already lane-aligned by the requester.
REQ-007 wmask  input  4  byte-lane write enables; bit i enables wdata[8i+7:8i]; 4'b0000 means no write.
REQ-008 ren  input  1  read request for addr.
REQ-009 rdata  output  32  registered read data.
REQ-010 tx_data  output  8  byte at the FIFO head.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts tx_data when tx_valid and tx_ready are both high.

Function
REQ-013 Address decode SHALL use addr[31:28]: 4'h0 selects RAM, 4'h8 selects MMIO, and any other value selects unmapped.
REQ-014 RAM word index SHALL be addr[log2(RAM_WORDS)+1:2]; higher RAM-region bits alias.
REQ-015 RAM write: on a clock edge with wmask≠0, each enabled lane of the indexed word SHALL update; disabled lanes SHALL hold.
REQ-016 Read latency SHALL be 1 cycle: with ren high at edge N, rdata SHALL show the selected value after edge N.
REQ-017 rdata SHALL hold its value on edges where ren is low.
REQ-018 A read and a write to the same word on the same edge SHALL return the pre-write data (read-before-write).
REQ-019 MMIO offset addr[7:0]=0x00 STATUS (read): bit0=FIFO not full, bit1=FIFO empty, bit2=overflow sticky, other bits 0.
REQ-020 A write to STATUS with wmask[0] set and wdata[2]=1 SHALL clear the overflow bit; all other STATUS bits are read-only.
REQ-021 MMIO 0x04 TXDATA: a write with wmask[0] set SHALL push wdata[7:0]; reads of TXDATA SHALL return 0.
REQ-022 MMIO 0x08 CYCLE (read): a 32-bit free-running counter that increments every cycle and wraps from 0xFFFFFFFF to 0.
REQ-023 MMIO 0x0C CYCCLR: any write (wmask≠0) SHALL load the counter with 0 at that edge; the counter increments from there; reads return 0.
REQ-024 Other MMIO offsets and unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-025 FIFO pop SHALL occur on an edge where tx_valid and tx_ready are both high; tx_data SHALL be the oldest entry; tx_data is don't-care when tx_valid is low.
REQ-026 FIFO push SHALL be accepted if the FIFO is not full, or if a pop occurs on the same edge.
REQ-027 A push while full with no pop SHALL drop the byte, leave the FIFO unchanged, and set overflow.
REQ-028 A simultaneous push and pop SHALL leave the occupancy count unchanged and preserve FIFO order.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be FIFO_DEPTH+1 values wide so that full and empty are distinguished.
REQ-030 STATUS reads SHALL reflect FIFO and overflow state sampled at the same edge as the read, i.e. before that edge's push or pop takes effect.

Reset
REQ-031 While reset is high, rdata=0, tx_valid=0, FIFO count=0, pointers=0, overflow=0, and CYCLE=0, regardless of clk.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset asserted mid-transaction SHALL discard any pending read result and any FIFO contents.
REQ-034 After reset deasserts, CYCLE SHALL read 1 when sampled at the first edge.

Verification
REQ-035 Write 0x0000_0010 with wdata=0xAABBCCDD and wmask=1111, then write wdata=0x11223344 with wmask=0101, then read -> rdata=0xAA22CC44 one cycle after the read.
REQ-036 Same-edge write 0x12345678 and read to a RAM word previously holding 0xDEADBEEF -> rdata=0xDEADBEEF; the next read -> 0x12345678.
REQ-037 With tx_ready=0, push bytes 0x01..0x05 -> STATUS=0x4 (full, overflow set); then tx_ready=1 -> tx_data sequence 0x01,0x02,0x03,0x04, then tx_valid=0 and STATUS bit1=1.
REQ-038 With FIFO full and tx_ready=1, push 0x99 -> accepted with no overflow; 0x99 emerges fourth.
REQ-039 Write CYCCLR, then read CYCLE two cycles later -> a small value consistent with REQ-023 (2 when the read is issued at the second edge after the clear); force the counter to 0xFFFFFFFF and advance -> it wraps to 0.
REQ-040 Assert reset asynchronously mid-cycle with 3 bytes queued and a read outstanding -> rdata=0 and tx_valid=0 immediately; the previously written RAM word still reads its old value after reset.
